// File: rtl/ft245_responder_if.sv
// FT245-style parallel FIFO bus between usb_sequencer (master) and ft245_responder (slave).
interface ft245_responder_if;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] usb_data_in;
    logic       rxf_n;
    logic       txe_n;
    logic [7:0] usb_data_out;
    logic       usb_data_oe;

    modport master (
        output rd_n, wr_n, usb_data_in,
        input  rxf_n, txe_n, usb_data_out, usb_data_oe
    );

    modport slave (
        input  rd_n, wr_n, usb_data_in,
        output rxf_n, txe_n, usb_data_out, usb_data_oe
    );
endinterface

// File: rtl/ft245_responder.sv
// FT245-style USB FIFO device model: serves RX bytes on rd_n strobes, captures TX bytes
// on wr_n strobes, with valid/ready byte streams on the host side.
module ft245_responder #(
    parameter int unsigned RX_DEPTH    = 16,
    parameter int unsigned TX_DEPTH    = 16,
    parameter int unsigned RXF_HOLDOFF = 2,
    parameter int unsigned TXE_HOLDOFF = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    ft245_responder_if.slave          usb,
    input  logic                      host_in_valid,
    input  logic [7:0]                host_in_data,
    output logic                      host_in_ready,
    output logic                      host_out_valid,
    output logic [7:0]                host_out_data,
    input  logic                      host_out_ready,
    input  logic                      err_clear,
    output logic [2:0]                err,
    output logic [$clog2(RX_DEPTH):0] rx_count,
    output logic [$clog2(TX_DEPTH):0] tx_count
);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RH_W  = (RXF_HOLDOFF > 1) ? $clog2(RXF_HOLDOFF) : 1;
    localparam int unsigned TH_W  = (TXE_HOLDOFF > 1) ? $clog2(TXE_HOLDOFF) : 1;
    localparam logic [RH_W-1:0] RH_LOAD = RH_W'((RXF_HOLDOFF > 0) ? RXF_HOLDOFF - 1 : 0);
    localparam logic [TH_W-1:0] TH_LOAD = TH_W'((TXE_HOLDOFF > 0) ? TXE_HOLDOFF - 1 : 0);
    localparam logic [RX_AW:0]  RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
    localparam logic [TX_AW:0]  TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_HOLD} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_HOLD} wr_state_t;

    logic rd_q, wr_q, bus_live;
    logic rd_fall, rd_rise, wr_fall, wr_rise, both_low;

    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rx_push, rx_pop, tx_push, tx_pop;
    logic rx_pop_req, tx_push_req;
    logic rd_start, rd_underrun, wr_overrun;

    rd_state_t       r_state, r_next;
    wr_state_t       w_state, w_next;
    logic [RH_W-1:0] r_hold, r_hold_next;
    logic [TH_W-1:0] w_hold, w_hold_next;

    logic [7:0]       data_out_q;
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;

    // Strobe registration; bus_live keeps both flags deasserted for the first cycle after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q     <= 1'b1;
            wr_q     <= 1'b1;
            bus_live <= 1'b0;
        end else begin
            rd_q     <= usb.rd_n;
            wr_q     <= usb.wr_n;
            bus_live <= 1'b1;
        end
    end

    assign rd_fall  = rd_q & ~usb.rd_n;
    assign rd_rise  = ~rd_q & usb.rd_n;
    assign wr_fall  = wr_q & ~usb.wr_n;
    assign wr_rise  = ~wr_q & usb.wr_n;
    assign both_low = ~usb.rd_n & ~usb.wr_n;

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == RX_FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == TX_FULL_CNT);

    // Read FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= R_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= r_next;
            r_hold  <= r_hold_next;
        end
    end

    always_comb begin
        r_next      = r_state;
        r_hold_next = r_hold;
        rx_pop_req  = 1'b0;
        rd_start    = 1'b0;
        rd_underrun = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (rd_fall) begin
                    if (!rx_empty) begin
                        r_next   = R_ACTIVE;
                        rd_start = 1'b1;
                    end else begin
                        rd_underrun = 1'b1;
                    end
                end
            end
            R_ACTIVE: begin
                if (rd_rise) begin
                    rx_pop_req = 1'b1;
                    if (RXF_HOLDOFF == 0) begin
                        r_next = R_IDLE;
                    end else begin
                        r_next      = R_HOLD;
                        r_hold_next = RH_LOAD;
                    end
                end
            end
            R_HOLD: begin
                rd_underrun = rd_fall;
                if (r_hold == '0) r_next = R_IDLE;
                else              r_hold_next = r_hold - RH_W'(1);
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        usb.rxf_n       = 1'b1;
        usb.usb_data_oe = 1'b0;
        case (r_state)
            R_IDLE:   usb.rxf_n = rx_empty | ~bus_live;
            R_ACTIVE: begin
                usb.rxf_n       = 1'b0;
                usb.usb_data_oe = 1'b1;
            end
            default:  usb.rxf_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      data_out_q <= '0;
        else if (rd_start) data_out_q <= rx_mem[rx_rd_ptr];
    end
    assign usb.usb_data_out = data_out_q;

    // Write FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_state <= W_IDLE;
            w_hold  <= '0;
        end else begin
            w_state <= w_next;
            w_hold  <= w_hold_next;
        end
    end

    always_comb begin
        w_next      = w_state;
        w_hold_next = w_hold;
        tx_push_req = 1'b0;
        wr_overrun  = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (wr_fall && !both_low) begin
                    if (!tx_full) w_next = W_ACTIVE;
                    else          wr_overrun = 1'b1;
                end
            end
            W_ACTIVE: begin
                if (wr_rise) begin
                    tx_push_req = 1'b1;
                    if (TXE_HOLDOFF == 0) begin
                        w_next = W_IDLE;
                    end else begin
                        w_next      = W_HOLD;
                        w_hold_next = TH_LOAD;
                    end
                end
            end
            W_HOLD: begin
                if (w_hold == '0) w_next = W_IDLE;
                else              w_hold_next = w_hold - TH_W'(1);
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        usb.txe_n = 1'b1;
        case (w_state)
            W_IDLE:   usb.txe_n = tx_full | ~bus_live;
            W_ACTIVE: usb.txe_n = 1'b0;
            default:  usb.txe_n = 1'b1;
        endcase
    end

    // RX FIFO: host pushes, bus reads pop
    assign rx_push = host_in_valid & ~rx_full;
    assign rx_pop  = rx_pop_req & ~rx_empty;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= host_in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            if (rx_push && !rx_pop)      rx_count <= rx_count + (RX_AW+1)'(1);
            else if (!rx_push && rx_pop) rx_count <= rx_count - (RX_AW+1)'(1);
        end
    end

    // TX FIFO: bus writes push, host pops
    assign tx_push = tx_push_req & ~tx_full;
    assign tx_pop  = host_out_ready & ~tx_empty;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= usb.usb_data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + (TX_AW+1)'(1);
            else if (!tx_push && tx_pop) tx_count <= tx_count - (TX_AW+1)'(1);
        end
    end

    assign host_in_ready  = ~rx_full;
    assign host_out_valid = ~tx_empty;
    assign host_out_data  = tx_mem[tx_rd_ptr];

    // Sticky errors; a new event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err <= '0;
        else          err <= (err & ~{3{err_clear}}) | {both_low, wr_overrun, rd_underrun};
    end
endmodule
